// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared constants and types for the RV32I pipeline.
//   - XLEN / REGW / CTRLW datapath constants
//   - bit offsets of the packed control bundle carried through ID/EX
//   - WBSel encoding (WB_MEM marks a load)
//   - occupancy state encoding of the ID/EX skid buffer
// No ports (package).
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int CTRLW = 16;

    // Control bundle layout, LSB first:
    // [0] PCSel, [1] RegWEn, [2] ASel, [3] BSel, [7:4] ALUSel,
    // [8] MemRW, [10:9] WBSel, [13:11] funct3, [15:14] spare
    localparam int CTRL_PCSEL      = 0;
    localparam int CTRL_REGWEN     = 1;
    localparam int CTRL_ASEL       = 2;
    localparam int CTRL_BSEL       = 3;
    localparam int CTRL_ALUSEL_LSB = 4;
    localparam int CTRL_ALUSEL_W   = 4;
    localparam int CTRL_MEMRW      = 8;
    localparam int CTRL_WBSEL_LSB  = 9;
    localparam int CTRL_WBSEL_W    = 2;
    localparam int CTRL_FUNCT3_LSB = 11;
    localparam int CTRL_FUNCT3_W   = 3;

    // WBSel encoding; a load writes back from memory.
    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Occupancy of the two-entry ID/EX buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // Decode-side helper: derive is_load from a control bundle.
    function automatic logic ctrl_is_load(input logic [CTRLW-1:0] ctrl);
        return ctrl[CTRL_WBSEL_LSB +: CTRL_WBSEL_W] == WB_MEM;
    endfunction

endpackage

// File: rtl/id_ex_hazard_cmp.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_cmp
// Combinational load-use match of one hazard source {valid, is_load, rd}
// against the source registers of the instruction presented by decode.
// Ports:
//   src_valid_i, src_is_load_i, src_rd_i  hazard source record
//   rs1_i, rs1_used_i, rs2_i, rs2_used_i  incoming instruction operands
//   hit_o                                 source conflicts with an operand
// -----------------------------------------------------------------------------
module id_ex_hazard_cmp #(
    parameter int REGW = 5
) (
    input  logic            src_valid_i,
    input  logic            src_is_load_i,
    input  logic [REGW-1:0] src_rd_i,
    input  logic [REGW-1:0] rs1_i,
    input  logic            rs1_used_i,
    input  logic [REGW-1:0] rs2_i,
    input  logic            rs2_used_i,
    output logic            hit_o
);

    logic src_live;

    // x0 is hard-wired zero, so a load into x0 can never be a producer.
    assign src_live = src_valid_i & src_is_load_i & (src_rd_i != '0);

    assign hit_o = src_live &
                   ((rs1_used_i & (rs1_i == src_rd_i)) |
                    (rs2_used_i & (rs2_i == src_rd_i)));

endmodule

// File: rtl/id_ex_skid.sv
// -----------------------------------------------------------------------------
// id_ex_skid
// ID/EX pipeline boundary implemented as a 2-entry elastic skid buffer with
// a synchronous flush and an optional load-use interlock.
//
// Handshake: a beat moves on a side when valid & ready are both high at the
// rising clock edge (acc = in_valid & in_ready, deq = out_valid & out_ready).
// A producer holding valid must keep its payload stable until accepted;
// out_* stays stable while out_valid & !out_ready. in_ready depends only on
// registered state and the incoming addresses, never on out_ready.
//
// Configuration macro: ID_EX_HAZARD_EN
//   defined   - load-use interlock, shadow load record and hazard_stall built
//   undefined - hazard_stall tied 0, in_ready = (state != FULL)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready/in_payload    decode side handshake and payload
//   in_rs1/in_rs2/in_rd             register addresses of incoming instr
//   in_rs1_used/in_rs2_used         incoming instr reads rs1 / rs2
//   in_is_load                      incoming instr is a load
//   out_valid/out_ready/out_payload execute side handshake and payload
//   out_rs1/out_rs2/out_rd          register addresses of head entry
//   out_is_load                     head entry is a load
//   flush                           drop buffered and incoming instructions
//   hazard_stall                    load-use interlock holding decode
// -----------------------------------------------------------------------------
import rv32_pkg::*;

module id_ex_skid #(
    parameter int XLEN      = rv32_pkg::XLEN,
    parameter int REGW      = rv32_pkg::REGW,
    parameter int CTRLW     = rv32_pkg::CTRLW,
    parameter int PAYLOAD_W = 4*XLEN + CTRLW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [REGW-1:0]      in_rs1,
    input  logic [REGW-1:0]      in_rs2,
    input  logic [REGW-1:0]      in_rd,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    input  logic                 in_is_load,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [REGW-1:0]      out_rs1,
    output logic [REGW-1:0]      out_rs2,
    output logic [REGW-1:0]      out_rd,
    output logic                 out_is_load,
    input  logic                 flush,
    output logic                 hazard_stall
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [REGW-1:0]      rs1;
        logic [REGW-1:0]      rs2;
        logic [REGW-1:0]      rd;
        logic                 is_load;
    } entry_t;

    occ_state_e state_q, state_d;
    entry_t     main_q, main_d;   // head entry, drives out_*
    entry_t     skid_q, skid_d;   // second entry, only valid in FULL
    entry_t     in_entry;

    logic acc;
    logic deq;

    assign in_entry = '{payload: in_payload, rs1: in_rs1, rs2: in_rs2,
                        rd: in_rd, is_load: in_is_load};

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    assign out_valid   = (state_q != EMPTY);
    assign out_payload = main_q.payload;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_is_load = main_q.is_load;

    // in_ready is held low during reset so nothing is taken while the
    // buffer is being cleared.
    assign in_ready = ~reset & (state_q != FULL) & ~hazard_stall;

`ifdef ID_EX_HAZARD_EN
    // Shadow of the load that left to EX last cycle: its data is not yet
    // available for forwarding, so a consumer must wait one more cycle.
    logic            shadow_valid_q, shadow_valid_d;
    logic [REGW-1:0] shadow_rd_q, shadow_rd_d;
    logic            hit_main, hit_skid, hit_shadow;

    id_ex_hazard_cmp #(.REGW(REGW)) u_cmp_main (
        .src_valid_i   (state_q != EMPTY),
        .src_is_load_i (main_q.is_load),
        .src_rd_i      (main_q.rd),
        .rs1_i         (in_rs1),
        .rs1_used_i    (in_rs1_used),
        .rs2_i         (in_rs2),
        .rs2_used_i    (in_rs2_used),
        .hit_o         (hit_main)
    );

    id_ex_hazard_cmp #(.REGW(REGW)) u_cmp_skid (
        .src_valid_i   (state_q == FULL),
        .src_is_load_i (skid_q.is_load),
        .src_rd_i      (skid_q.rd),
        .rs1_i         (in_rs1),
        .rs1_used_i    (in_rs1_used),
        .rs2_i         (in_rs2),
        .rs2_used_i    (in_rs2_used),
        .hit_o         (hit_skid)
    );

    // The shadow only ever records loads, so is_load is constant here.
    id_ex_hazard_cmp #(.REGW(REGW)) u_cmp_shadow (
        .src_valid_i   (shadow_valid_q),
        .src_is_load_i (1'b1),
        .src_rd_i      (shadow_rd_q),
        .rs1_i         (in_rs1),
        .rs1_used_i    (in_rs1_used),
        .rs2_i         (in_rs2),
        .rs2_used_i    (in_rs2_used),
        .hit_o         (hit_shadow)
    );

    assign hazard_stall = ~reset & in_valid & (hit_main | hit_skid | hit_shadow);

    always_comb begin
        shadow_valid_d = deq & main_q.is_load & ~flush;
        shadow_rd_d    = deq ? main_q.rd : shadow_rd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_valid_q <= 1'b0;
            shadow_rd_q    <= '0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            shadow_rd_q    <= shadow_rd_d;
        end
    end
`else
    // Operand-use flags only feed the interlock; stall generation lives in
    // the external hazard unit in this build.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = in_rs1_used ^ in_rs2_used;
    assign hazard_stall         = 1'b0;
`endif

    // Occupancy next state and entry movement.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = in_entry;
                end
            end
            ONE: begin
                if (acc && deq) begin
                    main_d = in_entry;
                end else if (acc) begin
                    state_d = FULL;
                    skid_d  = in_entry;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the head can move.
                if (deq) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flush empties the buffer; any data written above is stale and
        // unobservable because out_valid drops.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
